// File: rtl/uc_irq.sv
// uc_irq: instruction decode and control unit with a registered zero flag,
// return-stack occupancy tracking, stall handling and vectored interrupt
// entry/return.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   opcode[5:0]       current instruction opcode
//   z                 ALU zero output, captured into the branch flag
//   stall             freeze request; suppresses all side effects this cycle
//   irq[NUM_IRQ-1:0]  level-sensitive interrupt requests (bit 0 = highest)
//   we3, s_inm, s_inc, s_in, s_out, out_in, s_subrutina, s_ra, s_rel, op
//                     datapath controls
//   pc_en             PC register load enable
//   push, pop         return-stack write / read-advance strobes
//   s_irq             PC mux selects the interrupt vector
//   irq_vec           index of the interrupt being taken
//   irq_ack           one-hot acknowledge, entry cycle only
//   sp                return-stack occupancy
//   stk_err           sticky stack fault
//   ie                interrupt enable
//   in_isr            interrupt service state
module uc_irq #(
  parameter int STACK_DEPTH = 8,
  parameter int NUM_IRQ     = 4,
  localparam int SPW        = $clog2(STACK_DEPTH + 1),
  localparam int IRQW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               z,
  input  logic               stall,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               we3,
  output logic               s_inm,
  output logic               s_inc,
  output logic               s_in,
  output logic               s_out,
  output logic               out_in,
  output logic               s_subrutina,
  output logic               s_ra,
  output logic               s_rel,
  output logic [2:0]         op,
  output logic               pc_en,
  output logic               push,
  output logic               pop,
  output logic               s_irq,
  output logic [IRQW-1:0]    irq_vec,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [SPW-1:0]     sp,
  output logic               stk_err,
  output logic               ie,
  output logic               in_isr
);

  localparam logic [5:0] OP_RETI = 6'b111001;
  localparam logic [5:0] OP_REL  = 6'b111010;
  localparam logic [5:0] OP_CALL = 6'b111011;
  localparam logic [5:0] OP_RET  = 6'b111101;
  localparam logic [5:0] OP_OUT  = 6'b111110;
  localparam logic [5:0] OP_IN   = 6'b111111;
  localparam logic [5:0] OP_EI   = 6'b001101;
  localparam logic [5:0] OP_DI   = 6'b001110;

  localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  typedef enum logic {RUN, ISR} state_t;

  state_t         state, state_nxt;
  logic           flag, flag_nxt;
  logic           ie_nxt;
  logic           stk_err_nxt;
  logic [SPW-1:0] sp_nxt;
  logic [IRQW-1:0] irq_idx;
  logic           take_irq;

  // Lowest-numbered active request wins.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) irq_idx = IRQW'(i);
    end
  end

  // Entry needs a free stack slot for the interrupted PC; otherwise it waits.
  assign take_irq = (state == RUN) && ie && (|irq) && !stall && (sp < SP_MAX);
  assign in_isr   = (state == ISR);

  always_comb begin
    we3         = 1'b0;
    s_inm       = 1'b0;
    s_inc       = 1'b1;
    s_in        = 1'b0;
    s_out       = 1'b0;
    out_in      = 1'b0;
    s_subrutina = 1'b0;
    s_ra        = 1'b0;
    s_rel       = 1'b0;
    op          = 3'd0;
    pc_en       = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    s_irq       = 1'b0;
    irq_vec     = '0;
    irq_ack     = '0;
    state_nxt   = state;
    flag_nxt    = flag;
    ie_nxt      = ie;
    sp_nxt      = sp;
    stk_err_nxt = stk_err;

    if (take_irq) begin
      // The opcode on the bus is not executed; its PC is pushed so it
      // re-executes after RETI.
      s_irq     = 1'b1;
      s_inc     = 1'b0;
      push      = 1'b1;
      irq_vec   = irq_idx;
      irq_ack   = NUM_IRQ'(1) << irq_idx;
      sp_nxt    = sp + SP_ONE;
      ie_nxt    = 1'b0;
      state_nxt = ISR;
    end else begin
      casez (opcode)
        6'b??0???: begin
          we3      = 1'b1;
          op       = opcode[2:0];
          flag_nxt = z;
        end
        6'b??1000: begin
          we3   = 1'b1;
          s_inm = 1'b1;
        end
        6'b?01001: s_inc = 1'b0;
        6'b?01010: s_inc = ~flag;
        6'b?01011: s_inc = flag;
        6'b??1100: out_in = 1'b1;
        OP_REL: begin
          s_inc = 1'b0;
          s_rel = 1'b1;
        end
        OP_CALL: begin
          if (sp < SP_MAX) begin
            s_inc       = 1'b0;
            s_subrutina = 1'b1;
            push        = 1'b1;
            sp_nxt      = sp + SP_ONE;
          end else begin
            stk_err_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (sp != '0) begin
            s_inc  = 1'b0;
            s_ra   = 1'b1;
            pop    = 1'b1;
            sp_nxt = sp - SP_ONE;
          end else begin
            stk_err_nxt = 1'b1;
          end
        end
        OP_RETI: begin
          if ((state == ISR) && (sp != '0)) begin
            s_inc     = 1'b0;
            s_ra      = 1'b1;
            pop       = 1'b1;
            sp_nxt    = sp - SP_ONE;
            ie_nxt    = 1'b1;
            state_nxt = RUN;
          end else begin
            stk_err_nxt = 1'b1;
          end
        end
        OP_OUT: s_out = 1'b1;
        OP_IN: begin
          we3  = 1'b1;
          s_in = 1'b1;
        end
        OP_EI: if (state == RUN) ie_nxt = 1'b1;
        OP_DI: if (state == RUN) ie_nxt = 1'b0;
        default: ;
      endcase

      // A stalled cycle keeps its decode visible but commits nothing.
      if (stall) begin
        pc_en       = 1'b0;
        we3         = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        s_out       = 1'b0;
        out_in      = 1'b0;
        s_in        = 1'b0;
        irq_ack     = '0;
        state_nxt   = state;
        flag_nxt    = flag;
        ie_nxt      = ie;
        sp_nxt      = sp;
        stk_err_nxt = stk_err;
      end
    end

    if (reset) begin
      pc_en   = 1'b0;
      we3     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      s_out   = 1'b0;
      out_in  = 1'b0;
      s_in    = 1'b0;
      s_irq   = 1'b0;
      irq_ack = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      flag    <= 1'b0;
      ie      <= 1'b0;
      sp      <= '0;
      stk_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      flag    <= flag_nxt;
      ie      <= ie_nxt;
      sp      <= sp_nxt;
      stk_err <= stk_err_nxt;
    end
  end

endmodule

// File: tb/tb_uc_irq.sv
module tb_uc_irq;

  localparam logic [5:0] NOP  = 6'd45;
  localparam logic [5:0] CALL = 6'd59;
  localparam logic [5:0] RET  = 6'd61;
  localparam logic [5:0] RETI = 6'd57;
  localparam logic [5:0] EI   = 6'd13;
  localparam logic [5:0] DI   = 6'd14;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       stall;
  logic [3:0] irq;
  logic       we3, s_inm, s_inc, s_in, s_out, out_in, s_subrutina, s_ra, s_rel;
  logic [2:0] op;
  logic       pc_en, push, pop, s_irq;
  logic [1:0] irq_vec;
  logic [3:0] irq_ack;
  logic [3:0] sp;
  logic       stk_err, ie, in_isr;

  uc_irq #(.STACK_DEPTH(8), .NUM_IRQ(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .stall(stall), .irq(irq),
    .we3(we3), .s_inm(s_inm), .s_inc(s_inc), .s_in(s_in), .s_out(s_out),
    .out_in(out_in), .s_subrutina(s_subrutina), .s_ra(s_ra), .s_rel(s_rel),
    .op(op), .pc_en(pc_en), .push(push), .pop(pop), .s_irq(s_irq),
    .irq_vec(irq_vec), .irq_ack(irq_ack), .sp(sp), .stk_err(stk_err),
    .ie(ie), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we3, s_inm, s_inc, s_in, s_out, out_in, s_sub, s_ra, s_rel;
    logic [2:0] op;
    logic       pc_en, push, pop, s_irq;
    logic [1:0] irq_vec;
    logic [3:0] irq_ack;
    logic [3:0] sp;
    logic       stk_err, ie, in_isr;
  } exp_t;

  exp_t q[$];
  int   n_err;
  int   n_checks;

  logic       m_flag, m_ie, m_err, m_isr;
  logic [3:0] m_sp;
  logic       n_flag, n_ie, n_err_st, n_isr;
  logic [3:0] n_sp;

  // Reference behaviour for one cycle: expected outputs plus next state.
  task automatic model(input logic [5:0] opc, input logic zz, input logic st,
                       input logic [3:0] rq, input logic rst);
    exp_t e;
    int idx;
    e = '0;
    e.s_inc = 1'b1;
    e.pc_en = 1'b1;
    e.sp = m_sp; e.stk_err = m_err; e.ie = m_ie; e.in_isr = m_isr;
    n_flag = m_flag; n_ie = m_ie; n_err_st = m_err; n_isr = m_isr; n_sp = m_sp;
    if (!m_isr && m_ie && rq != 4'b0 && !st && m_sp < 4'd8) begin
      idx = 0;
      while (idx < 3 && !rq[idx]) idx++;
      e.s_irq = 1'b1; e.s_inc = 1'b0; e.push = 1'b1;
      e.irq_vec = 2'(idx);
      e.irq_ack = 4'b0001 << idx;
      n_sp = m_sp + 4'd1; n_ie = 1'b0; n_isr = 1'b1;
    end else if (opc[3] == 1'b0) begin
      e.we3 = 1'b1; e.op = opc[2:0]; n_flag = zz;
    end else if (opc[2:0] == 3'b000) begin
      e.we3 = 1'b1; e.s_inm = 1'b1;
    end else if (opc[4:0] == 5'b01001) begin
      e.s_inc = 1'b0;
    end else if (opc[4:0] == 5'b01010) begin
      e.s_inc = !m_flag;
    end else if (opc[4:0] == 5'b01011) begin
      e.s_inc = m_flag;
    end else if (opc[2:0] == 3'b100) begin
      e.out_in = 1'b1;
    end else begin
      case (opc)
        6'd58: begin e.s_inc = 1'b0; e.s_rel = 1'b1; end
        6'd59: if (m_sp < 4'd8) begin
                 e.s_inc = 1'b0; e.s_sub = 1'b1; e.push = 1'b1; n_sp = m_sp + 4'd1;
               end else n_err_st = 1'b1;
        6'd61: if (m_sp > 4'd0) begin
                 e.s_inc = 1'b0; e.s_ra = 1'b1; e.pop = 1'b1; n_sp = m_sp - 4'd1;
               end else n_err_st = 1'b1;
        6'd57: if (m_isr && m_sp > 4'd0) begin
                 e.s_inc = 1'b0; e.s_ra = 1'b1; e.pop = 1'b1; n_sp = m_sp - 4'd1;
                 n_ie = 1'b1; n_isr = 1'b0;
               end else n_err_st = 1'b1;
        6'd62: e.s_out = 1'b1;
        6'd63: begin e.we3 = 1'b1; e.s_in = 1'b1; end
        6'd13: if (!m_isr) n_ie = 1'b1;
        6'd14: if (!m_isr) n_ie = 1'b0;
        default: ;
      endcase
    end
    if (st) begin
      e.pc_en = 1'b0; e.we3 = 1'b0; e.push = 1'b0; e.pop = 1'b0;
      e.s_out = 1'b0; e.out_in = 1'b0; e.s_in = 1'b0; e.irq_ack = 4'b0;
      n_flag = m_flag; n_ie = m_ie; n_err_st = m_err; n_isr = m_isr; n_sp = m_sp;
    end
    if (rst) begin
      e.pc_en = 1'b0; e.we3 = 1'b0; e.push = 1'b0; e.pop = 1'b0; e.s_out = 1'b0;
      e.out_in = 1'b0; e.s_in = 1'b0; e.s_irq = 1'b0; e.irq_ack = 4'b0;
      n_flag = 1'b0; n_ie = 1'b0; n_err_st = 1'b0; n_isr = 1'b0; n_sp = 4'd0;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    logic [15:0] oc, ec;
    n_checks++;
    assert (q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      oc = {we3, s_inm, s_inc, s_in, s_out, out_in, s_subrutina, s_ra, s_rel,
            op, pc_en, push, pop, s_irq};
      ec = {e.we3, e.s_inm, e.s_inc, e.s_in, e.s_out, e.out_in, e.s_sub, e.s_ra,
            e.s_rel, e.op, e.pc_en, e.push, e.pop, e.s_irq};
      chk(tag, "ctrl", 32'(oc), 32'(ec));
      chk(tag, "irq_ack", 32'(irq_ack), 32'(e.irq_ack));
      if (e.s_irq) chk(tag, "irq_vec", 32'(irq_vec), 32'(e.irq_vec));
      chk(tag, "sp", 32'(sp), 32'(e.sp));
      chk(tag, "stk_err", 32'(stk_err), 32'(e.stk_err));
      chk(tag, "ie", 32'(ie), 32'(e.ie));
      chk(tag, "in_isr", 32'(in_isr), 32'(e.in_isr));
    end
  endtask

  task automatic step(input string tag, input logic [5:0] opc, input logic zz,
                      input logic st, input logic [3:0] rq, input logic rst);
    reset = rst; opcode = opc; z = zz; stall = st; irq = rq;
    model(opc, zz, st, rq, rst);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    m_flag = n_flag; m_ie = n_ie; m_err = n_err_st; m_isr = n_isr; m_sp = n_sp;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0;
    n_checks = 0;
    reset = 1'b1; opcode = NOP; z = 1'b0; stall = 1'b0; irq = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    m_flag = 1'b0; m_ie = 1'b0; m_err = 1'b0; m_isr = 1'b0; m_sp = 4'd0;

    step("reset_state", NOP, 1'b0, 1'b0, 4'b0, 1'b0);

    // Decode sweep with the registered flag clear, then set.
    for (int i = 0; i < 64; i++)
      step($sformatf("dec_f0_op%0d", i), 6'(i), 1'b0, 1'b0, 4'b0, 1'b0);
    step("rst_a", NOP, 1'b0, 1'b0, 4'b0, 1'b1);
    step("set_flag", 6'd0, 1'b1, 1'b0, 4'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      step($sformatf("dec_f1_op%0d", i), 6'(i), 1'b1, 1'b0, 4'b0, 1'b0);

    // Reset cycle suppresses strobes even for CALL with a request pending.
    step("rst_strobes", CALL, 1'b0, 1'b0, 4'b0001, 1'b1);

    // Stack overflow and underflow.
    for (int i = 0; i < 9; i++)
      step($sformatf("ovf_call%0d", i), CALL, 1'b0, 1'b0, 4'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      step($sformatf("unf_ret%0d", i), RET, 1'b0, 1'b0, 4'b0, 1'b0);
    step("after_unf", NOP, 1'b0, 1'b0, 4'b0, 1'b0);
    step("rst_b", NOP, 1'b0, 1'b0, 4'b0, 1'b1);

    // Interrupt entry, ISR behaviour and return.
    step("ei", EI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("irq_entry", 6'b000011, 1'b0, 1'b0, 4'b0110, 1'b0);
    step("isr_nop", NOP, 1'b0, 1'b0, 4'b0110, 1'b0);
    step("isr_ei", EI, 1'b0, 1'b0, 4'b0110, 1'b0);
    step("isr_call", CALL, 1'b0, 1'b0, 4'b0, 1'b0);
    step("isr_ret", RET, 1'b0, 1'b0, 4'b0, 1'b0);
    step("isr_reti", RETI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("post_reti", NOP, 1'b0, 1'b0, 4'b0, 1'b0);
    step("reti_in_run", RETI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("post_reti_run", NOP, 1'b0, 1'b0, 4'b0, 1'b0);
    step("di", DI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("irq_masked", NOP, 1'b0, 1'b0, 4'b1000, 1'b0);
    step("rst_c", NOP, 1'b0, 1'b0, 4'b0, 1'b1);

    // Full stack defers the interrupt until a slot frees up.
    step("ei_full", EI, 1'b0, 1'b0, 4'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step($sformatf("fill_call%0d", i), CALL, 1'b0, 1'b0, 4'b0, 1'b0);
    step("deferred", NOP, 1'b0, 1'b0, 4'b1000, 1'b0);
    step("deferred_ret", RET, 1'b0, 1'b0, 4'b1000, 1'b0);
    step("deferred_take", NOP, 1'b0, 1'b0, 4'b1000, 1'b0);
    step("rst_d", NOP, 1'b0, 1'b0, 4'b0, 1'b1);

    // Stall beats a pending interrupt; on release the interrupt goes first.
    step("ei_stall", EI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("stall_call", CALL, 1'b0, 1'b1, 4'b0100, 1'b0);
    step("stall_release", CALL, 1'b0, 1'b0, 4'b0100, 1'b0);
    step("stall_isr", RETI, 1'b0, 1'b1, 4'b0, 1'b0);
    step("reti_after_stall", RETI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("call_reexec", CALL, 1'b0, 1'b0, 4'b0, 1'b0);
    step("rst_e", NOP, 1'b0, 1'b0, 4'b0, 1'b1);

    // Reset in the middle of an ISR with three stack entries.
    step("ei_mid", EI, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mid_call0", CALL, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mid_call1", CALL, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mid_entry", NOP, 1'b0, 1'b0, 4'b0001, 1'b0);
    step("mid_reset", CALL, 1'b0, 1'b0, 4'b0001, 1'b1);
    step("post_mid_reset", NOP, 1'b0, 1'b0, 4'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
